// File: rtl/aes_pkg.sv
// Shared AES definitions: round-count constants, FSM encoding, GF(2^8) xtime
// and byte/column position helpers for the column-major 128-bit state layout.
package aes_pkg;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // LSB position of byte s(r,c); s(0,0) occupies bits [127:120].
  function automatic int byte_lsb(input int r, input int c);
    return 120 - 8 * (4 * c + r);
  endfunction

  // LSB position of column c; column 0 occupies bits [127:96].
  function automatic int col_lsb(input int c);
    return 96 - 32 * c;
  endfunction

endpackage

// File: rtl/aes_mixcolumn.sv
// Combinational MixColumns on one 32-bit column; bits [31:24] hold row 0.
module aes_mixcolumn
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] b0, b1, b2, b3;
  logic [7:0] x0, x1, x2, x3;

  assign b0 = col_in[31:24];
  assign b1 = col_in[23:16];
  assign b2 = col_in[15:8];
  assign b3 = col_in[7:0];

  assign x0 = xtime(b0);
  assign x1 = xtime(b1);
  assign x2 = xtime(b2);
  assign x3 = xtime(b3);

  // 3*b is written as xtime(b) ^ b.
  assign col_out[31:24] = x0 ^ (x1 ^ b1) ^ b2 ^ b3;
  assign col_out[23:16] = b0 ^ x1 ^ (x2 ^ b2) ^ b3;
  assign col_out[15:8]  = b0 ^ b1 ^ x2 ^ (x3 ^ b3);
  assign col_out[7:0]   = (x0 ^ b0) ^ b1 ^ b2 ^ x3;

endmodule

// File: rtl/aes_round_iter.sv
// Iterative AES encryption engine: one round per clock, SubBytes external via
// sb_in/sb, round keys fetched from an external store addressed by rk_idx.
module aes_round_iter
  import aes_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic [127:0] sb_in,
  input  logic [127:0] sb,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic [1:0]   dbg_state
);

  localparam logic [3:0] NR_L = 4'(NR);

  state_t       fsm_q, fsm_d;
  logic [127:0] state_q;
  logic [3:0]   round_q;
  logic [127:0] sr, mc, round_out;
  logic         last_round;

  // ShiftRows: out (r,c) takes in (r,(c+r) mod 4).
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign sr[byte_lsb(r, c) +: 8] = sb[byte_lsb(r, (c + r) % 4) +: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_mixcolumn u_mix (
      .col_in (sr[col_lsb(c) +: 32]),
      .col_out(mc[col_lsb(c) +: 32])
    );
  end

  assign last_round = (round_q == NR_L);
  assign round_out  = (last_round ? sr : mc) ^ rk;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in IDLE, out_valid only in DONE, and
  // data_out is held stable until out_ready is seen.
  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = 4'd0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_d = RUN;
      end
      RUN: begin
        rk_idx = round_q;
        if (last_round) fsm_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      case (fsm_q)
        IDLE: begin
          // rk is only consumed on accept, so an undriven key store is harmless.
          if (in_valid) begin
            state_q <= data_in ^ rk;
            round_q <= 4'd1;
          end
        end
        RUN: begin
          state_q <= round_out;
          round_q <= round_q + 4'd1;
        end
        DONE: begin
          if (out_ready) round_q <= 4'd0;
        end
        default: round_q <= 4'd0;
      endcase
    end
  end

  assign sb_in     = state_q;
  assign data_out  = state_q;
  assign dbg_state = fsm_q;

endmodule
